// File: rtl/spike_encoder_pkg.sv
// ============================================================================
// Module   : snn_pkg
// Brief    : Shared spike-encoding constants, value type and config check.
// Revision : 1.0
// ============================================================================
`default_nettype none

package snn_pkg;

    localparam int WRES = 3;
    localparam int WMAX = (1 << WRES) - 1;
    localparam int PW   = 1 << WRES;

    typedef logic [WRES-1:0] spk_val_t;

    // The latest pulse must end before the next wave reset.
    function automatic bit gamma_len_ok(input int gamma_len, input int offset, input int pw);
        return (offset >= 1) && (gamma_len >= offset + 2 * pw - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spike_encoder_if.sv
// ============================================================================
// Module   : spike_encoder_if
// Brief    : Valid/ready vector input bus for the spike encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface spike_encoder_if #(
    parameter int P    = 64,
    parameter int WRES = 3
);

    logic                       in_valid;
    logic                       in_ready;
    logic [P-1:0][WRES-1:0]     in_data;
    logic [P-1:0]               in_mask;

    modport master (
        output in_valid,
        output in_data,
        output in_mask,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mask,
        output in_ready
    );

endinterface

`default_nettype wire

// File: rtl/spike_encoder_pulse_gen.sv
// ============================================================================
// Module   : spike_pulse_gen
// Brief    : Per-channel temporal pulse compare. Build macro SPIKE_INVERT_EN
//            makes larger values spike earlier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spike_pulse_gen #(
    parameter int WRES    = 3,
    parameter int PHASE_W = 5,
    parameter int OFFSET  = 1
) (
    input  wire logic [PHASE_W-1:0] i_phase,
    input  wire logic [WRES-1:0]    i_value,
    input  wire logic               i_mask,
    input  wire logic               i_act_valid,
    output logic                    o_pulse
);

    localparam int c_cmp_w = WRES + 1 + PHASE_W;
    localparam int c_pw    = 1 << WRES;

    logic [WRES-1:0]    w_val;
    logic [c_cmp_w-1:0] w_phase;
    logic [c_cmp_w-1:0] w_start;
    logic [c_cmp_w-1:0] w_end;

`ifdef SPIKE_INVERT_EN
    // Bitwise inversion equals WMAX - value for an all-ones WMAX.
    assign w_val = ~i_value;
`else
    assign w_val = i_value;
`endif

    assign w_phase = c_cmp_w'(i_phase);
    assign w_start = c_cmp_w'(OFFSET) + c_cmp_w'(w_val);
    assign w_end   = w_start + c_cmp_w'(c_pw);

    assign o_pulse = i_act_valid & i_mask & (w_phase >= w_start) & (w_phase < w_end);

endmodule

`default_nettype wire

// File: rtl/spike_encoder.sv
// ============================================================================
// Module   : spike_encoder
// Brief    : Gamma-wave phase counter, one-deep input buffer and per-channel
//            temporal spike generation. Optional macro: SPIKE_INVERT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spike_encoder #(
    parameter int P         = 64,
    parameter int WRES      = 3,
    parameter int GAMMA_LEN = 24,
    parameter int OFFSET    = 1
) (
    input  wire logic           clk,
    input  wire logic           rstb,
    spike_encoder_if.slave      in_bus,
    output logic [P-1:0]        input_spikes,
    output logic                grst,
    output logic                wave_valid,
    output logic [7:0]          wave_id
);

    import snn_pkg::*;

    localparam int                 c_pw      = 1 << WRES;
    localparam int                 c_phase_w = $clog2(GAMMA_LEN);
    localparam logic [c_phase_w-1:0] c_last  = c_phase_w'(GAMMA_LEN - 1);

    if (!gamma_len_ok(GAMMA_LEN, OFFSET, c_pw)) begin : g_bad_cfg
        $error("spike_encoder: GAMMA_LEN too short for OFFSET/pulse width, or OFFSET < 1");
    end

    logic [c_phase_w-1:0]       r_phase;
    logic                       r_pend_valid;
    logic [P-1:0][WRES-1:0]     r_pend_data;
    logic [P-1:0]               r_pend_mask;
    logic                       r_act_valid;
    logic [P-1:0][WRES-1:0]     r_act_data;
    logic [P-1:0]               r_act_mask;
    logic [7:0]                 r_wave_id;

    logic                       w_load;
    logic                       w_accept;

    assign w_load   = (r_phase == c_last);
    assign w_accept = in_bus.in_valid && !r_pend_valid;

    // Reset parks the counter on the last phase so the first edge is a load edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_phase <= c_last;
        end else if (w_load) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // Accept can only coincide with a load when pend is empty, so the loaded
    // wave is idle and the new vector waits a full wave in pend.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_pend_mask  <= '0;
        end else if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_data  <= in_bus.in_data;
            r_pend_mask  <= in_bus.in_mask;
        end else if (w_load) begin
            r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_act_valid <= 1'b0;
            r_act_data  <= '0;
            r_act_mask  <= '0;
            r_wave_id   <= '0;
        end else if (w_load) begin
            r_act_valid <= r_pend_valid;
            r_act_data  <= r_pend_data;
            r_act_mask  <= r_pend_mask;
            if (r_pend_valid) begin
                r_wave_id <= r_wave_id + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < P; i++) begin : g_chan
        spike_pulse_gen #(
            .WRES    (WRES),
            .PHASE_W (c_phase_w),
            .OFFSET  (OFFSET)
        ) u_pulse (
            .i_phase     (r_phase),
            .i_value     (r_act_data[i]),
            .i_mask      (r_act_mask[i]),
            .i_act_valid (r_act_valid),
            .o_pulse     (input_spikes[i])
        );
    end

    assign in_bus.in_ready = !r_pend_valid;
    assign grst            = (r_phase == '0);
    assign wave_valid      = r_act_valid;
    assign wave_id         = r_wave_id;

endmodule

`default_nettype wire

// File: tb/tb_spike_encoder.sv
// ============================================================================
// Module   : tb_spike_encoder
// Brief    : Self-checking bench for spike_encoder against a wave-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spike_encoder;

    localparam int P         = 64;
    localparam int WRES      = 3;
    localparam int G         = 24;
    localparam int OFFSET    = 1;
    localparam int WMAX      = (1 << WRES) - 1;
    localparam int PW        = 1 << WRES;

    logic           clk = 1'b0;
    logic           rstb;
    logic [P-1:0]   input_spikes;
    logic           grst;
    logic           wave_valid;
    logic [7:0]     wave_id;

    spike_encoder_if #(.P(P), .WRES(WRES)) bus ();

    spike_encoder #(
        .P         (P),
        .WRES      (WRES),
        .GAMMA_LEN (G),
        .OFFSET    (OFFSET)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .in_bus       (bus),
        .input_spikes (input_spikes),
        .grst         (grst),
        .wave_valid   (wave_valid),
        .wave_id      (wave_id)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: wave phase, one-slot pending buffer, vector in flight.
    int           m_phase;
    bit           m_pend_valid;
    int           m_pend_data [P];
    bit [P-1:0]   m_pend_mask;
    bit           m_act_valid;
    int           m_act_data [P];
    bit [P-1:0]   m_act_mask;
    int           m_wave_id;
    int           drv_data [P];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P-1:0] exp_spikes();
        logic [P-1:0] s;
        s = '0;
        for (int i = 0; i < P; i++) begin
            int v;
            v = m_act_data[i];
`ifdef SPIKE_INVERT_EN
            v = WMAX - v;
`endif
            s[i] = m_act_valid && m_act_mask[i] &&
                   (m_phase >= OFFSET + v) && (m_phase < OFFSET + v + PW);
        end
        return s;
    endfunction

    task automatic model_reset();
        m_phase      = G - 1;
        m_pend_valid = 0;
        m_act_valid  = 0;
        m_wave_id    = 0;
    endtask

    task automatic check_all();
        check("in_ready",     64'(bus.in_ready),  64'(!m_pend_valid));
        check("grst",         64'(grst),          64'(m_phase == 0));
        check("wave_valid",   64'(wave_valid),    64'(m_act_valid));
        check("wave_id",      64'(wave_id),       64'(m_wave_id));
        check("input_spikes", 64'(input_spikes),  64'(exp_spikes()));
    endtask

    task automatic drive(input bit v, input bit [P-1:0] mask);
        bus.in_valid = v;
        bus.in_mask  = mask;
        for (int i = 0; i < P; i++) bus.in_data[i] = WRES'(drv_data[i]);
    endtask

    task automatic randomize_data();
        for (int i = 0; i < P; i++) drv_data[i] = $urandom_range(0, WMAX);
    endtask

    // One clock: predict from pre-edge state, advance, compare everything.
    task automatic cycle(output bit acc);
        bit load;
        acc  = bus.in_valid && !m_pend_valid;
        load = (m_phase == G - 1);
        @(posedge clk);
        #1;
        if (load) begin
            m_act_valid = m_pend_valid;
            m_act_data  = m_pend_data;
            m_act_mask  = m_pend_mask;
            if (m_pend_valid) begin
                m_wave_id    = (m_wave_id + 1) % 256;
                m_pend_valid = 0;
            end
        end
        if (acc) begin
            m_pend_valid = 1;
            m_pend_data  = drv_data;
            m_pend_mask  = bus.in_mask;
        end
        m_phase = (m_phase + 1) % G;
        check_all();
    endtask

    task automatic run(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(acc);
    endtask

    task automatic run_until_phase(input int ph);
        bit acc;
        for (int k = 0; k < G && m_phase != ph; k++) cycle(acc);
    endtask

    // Holds in_valid until accepted; a stall beyond three waves is a failure.
    task automatic send(input bit [P-1:0] mask, input bit keep_valid);
        bit acc;
        bit done;
        done = 0;
        drive(1'b1, mask);
        for (int k = 0; k < 3 * G && !done; k++) begin
            cycle(acc);
            done = acc;
        end
        check("send_accepted", 64'(done), 64'd1);
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        bit done;

        rstb = 1'b0;
        for (int i = 0; i < P; i++) drv_data[i] = 0;
        drive(1'b0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_spikes",     64'(input_spikes),   64'd0);
        check("rst_grst",       64'(grst),           64'd0);
        check("rst_wave_valid", 64'(wave_valid),     64'd0);
        check("rst_in_ready",   64'(bus.in_ready),   64'd1);
        check("rst_wave_id",    64'(wave_id),        64'd0);
        #2 rstb = 1'b1;

        // Idle waves: grst on cycles 1, 25, 49 after release.
        for (int n = 1; n <= 60; n++) begin
            cycle(acc);
            check("idle_grst_cycle", 64'(grst), 64'((n % G) == 1));
        end

        // Directed vector at phase 10.
        run_until_phase(10);
        for (int i = 0; i < P; i++) drv_data[i] = 0;
        drv_data[1] = 7;
        drv_data[2] = 3;
        send(P'(3'b111), 1'b0);
        run(2 * G);

        // Back-to-back V1, V2, V3 with in_valid held high.
        randomize_data();
        send('1, 1'b1);
        randomize_data();
        send('1, 1'b1);
        randomize_data();
        send('1, 1'b0);
        run(3 * G);

        // Masked channel with value 0 stays silent.
        randomize_data();
        drv_data[0] = 0;
        send({{(P-1){1'b1}}, 1'b0}, 1'b0);
        run(2 * G);

        // Accept exactly on the load edge with pend empty.
        run_until_phase(G - 1);
        randomize_data();
        drive(1'b1, '1);
        cycle(acc);
        check("load_edge_accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        run(G - 1);
        check("load_edge_idle_wave", 64'(wave_valid), 64'd0);
        run(G + 2);

        // Reset at phase 6 of an active wave with a vector also pending.
        for (int i = 0; i < P; i++) drv_data[i] = 0;
        send('1, 1'b0);
        randomize_data();
        done = 0;
        for (int k = 0; k < 3 * G && !done; k++) begin
            cycle(acc);
            done = m_act_valid && (m_phase == 2);
        end
        check("reach_active_wave", 64'(done), 64'd1);
        send('1, 1'b0);
        run_until_phase(6);
        check("pre_rst_spiking", 64'(input_spikes != '0), 64'd1);
        rstb = 1'b0;
        #1;
        model_reset();
        check("midrst_spikes",     64'(input_spikes), 64'd0);
        check("midrst_in_ready",   64'(bus.in_ready), 64'd1);
        check("midrst_wave_valid", 64'(wave_valid),   64'd0);
        check("midrst_grst",       64'(grst),         64'd0);
        @(posedge clk);
        #3 rstb = 1'b1;
        cycle(acc);
        check("post_rst_grst", 64'(grst), 64'd1);
        run(G);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            if (!bus.in_valid) begin
                randomize_data();
                drive(($urandom % 3) == 0, P'({$urandom, $urandom}));
            end
            cycle(acc);
            if (acc) bus.in_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
